inst_bus_arbiter: RTL and testbench

//  Shares the single instruction-ROM port between two requesters: the IF-stage fetch (IF) and the
//  MEM-stage code-space read (MEM, for loads from the text segment).
//  It arbitrates once per cycle and drives the ROM chip-enable and address for the winner.
//  It registers the ROM data and returns it one cycle later with a per-requester valid.
//  It sits between the fetch/MEM stages and the instruction ROM slave.

---
 rtl/inst_bus_arbiter_pkg.sv | 16 +
 rtl/inst_bus_arbiter_if.sv | 14 +
 rtl/inst_bus_arbiter_starve_counter.sv | 29 ++
 rtl/inst_bus_arbiter.sv | 85 ++++++++
 tb/tb_inst_bus_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/inst_bus_arbiter_pkg.sv
// rtl/inst_bus_arbiter_pkg.sv - shared types for the instruction-ROM port arbiter
package inst_bus_arbiter_pkg;

  typedef logic [31:0] inst_data_t;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Encodes which response, if any, is presented this cycle
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF_RESP,
    ARB_MEM_RESP
  } arb_state_t;

endpackage

// File: rtl/inst_bus_arbiter_if.sv
// rtl/inst_bus_arbiter_if.sv - instruction ROM bus (chip enable, address, read data)
interface inst_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  import inst_bus_arbiter_pkg::*;

  logic              ce;
  logic [ADDR_W-1:0] addr;
  inst_data_t        data;

  modport master (output ce, output addr, input data);
  modport slave  (input ce, input addr, output data);

endinterface

// File: rtl/inst_bus_arbiter_starve_counter.sv
// rtl/inst_bus_arbiter_starve_counter.sv - saturating count of consecutive IF losses
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic mem_gnt,
  output logic force_if
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (!if_req || if_gnt) begin
      cnt <= 4'd0;
    end else if (mem_gnt && cnt != CNT_MAX) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_if = (cnt == CNT_MAX);

endmodule

// File: rtl/inst_bus_arbiter.sv
// rtl/inst_bus_arbiter.sv - shares the instruction ROM between IF fetch and MEM code reads
module inst_bus_arbiter
  import inst_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_flush,
  output logic               if_gnt,
  output logic               if_rvalid,
  output inst_data_t         if_rdata,

  input  logic               mem_req,
  input  logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_gnt,
  output logic               mem_rvalid,
  output inst_data_t         mem_rdata,

  inst_bus_arbiter_if.master rom
);

  arb_state_t state;
  logic       force_if;
  logic       flush_q;
  inst_data_t if_data_q;
  inst_data_t if_rdata_hold;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .mem_gnt  (mem_gnt),
    .force_if (force_if)
  );

  // MEM has priority unless IF has lost too many times in a row
  assign if_gnt  = rst_n && if_req && (!mem_req || force_if);
  assign mem_gnt = rst_n && mem_req && !(if_req && force_if);

  always_comb begin
    rom.ce   = CHIP_DISABLE;
    rom.addr = '0;
    if (if_gnt) begin
      rom.ce   = CHIP_ENABLE;
      rom.addr = if_addr;
    end else if (mem_gnt) begin
      rom.ce   = CHIP_ENABLE;
      rom.addr = mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      flush_q       <= 1'b0;
      if_data_q     <= '0;
      if_rdata_hold <= '0;
      mem_rdata     <= '0;
    end else begin
      if (if_gnt)       state <= ARB_IF_RESP;
      else if (mem_gnt) state <= ARB_MEM_RESP;
      else              state <= ARB_IDLE;

      flush_q <= if_gnt && if_flush;
      if (if_gnt)    if_data_q     <= rom.data;
      if (if_rvalid) if_rdata_hold <= if_data_q;
      if (mem_gnt)   mem_rdata     <= rom.data;
    end
  end

  // A flush in the presentation cycle also kills the response, so if_rdata
  // only adopts the fetched word when the response is actually delivered.
  assign if_rvalid  = (state == ARB_IF_RESP) && !flush_q && !if_flush;
  assign if_rdata   = if_rvalid ? if_data_q : if_rdata_hold;
  assign mem_rvalid = (state == ARB_MEM_RESP);

endmodule

// File: tb/tb_inst_bus_arbiter.sv
// tb/tb_inst_bus_arbiter.sv - directed vector bench for inst_bus_arbiter
module tb_inst_bus_arbiter;
  import inst_bus_arbiter_pkg::*;

  typedef struct packed {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        mem_req;
    logic [31:0] mem_addr;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        mem_gnt;
    logic        ce;
    logic [31:0] rom_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, mem_req;
  logic [31:0] if_addr, mem_addr;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
  inst_data_t  if_rdata, mem_rdata;

  int total  = 0;
  int passed = 0;

  inst_bus_arbiter_if #(.ADDR_W(32)) rom_bus ();

  // ROM holds its own word index at every word address
  assign rom_bus.data = rom_bus.addr >> 2;

  inst_bus_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rom        (rom_bus.master)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                             input logic mr, input logic [31:0] ma,
                             input logic ig, input logic mg, input logic ce, input logic [31:0] ra,
                             input logic irv, input logic [31:0] ird,
                             input logic mrv, input logic [31:0] mrd);
    vec_t x;
    x.stim = '{r, ir, ia, fl, mr, ma};
    x.exp  = '{ig, mg, ce, ra, irv, ird, mrv, mrd};
    return x;
  endfunction

  task automatic drive(input in_t s);
    rst_n    = s.rst_n;
    if_req   = s.if_req;
    if_addr  = s.if_addr;
    if_flush = s.if_flush;
    mem_req  = s.mem_req;
    mem_addr = s.mem_addr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vq[$];

  initial begin
    out_t got;
    in_t  s;

    // reset (3 rows) then IF-only stream 0x0,0x4,0x8
    vq.push_back(v(0,1,32'h0,0,0,32'h0,   0,0,0,32'h0,    0,32'h0, 0,32'h0));
    vq.push_back(v(0,1,32'h0,0,0,32'h0,   0,0,0,32'h0,    0,32'h0, 0,32'h0));
    vq.push_back(v(0,1,32'h0,0,0,32'h0,   0,0,0,32'h0,    0,32'h0, 0,32'h0));
    vq.push_back(v(1,1,32'h0,0,0,32'h0,   1,0,1,32'h0,    0,32'h0, 0,32'h0));
    vq.push_back(v(1,1,32'h4,0,0,32'h0,   1,0,1,32'h4,    1,32'h0, 0,32'h0));
    vq.push_back(v(1,1,32'h8,0,0,32'h0,   1,0,1,32'h8,    1,32'h1, 0,32'h0));
    vq.push_back(v(1,0,32'h0,0,0,32'h0,   0,0,0,32'h0,    1,32'h2, 0,32'h0));
    // simultaneous: MEM first, IF next
    vq.push_back(v(1,1,32'hC,0,1,32'h100, 0,1,1,32'h100,  0,32'h2, 0,32'h0));
    vq.push_back(v(1,1,32'hC,0,0,32'h100, 1,0,1,32'hC,    0,32'h2, 1,32'h40));
    vq.push_back(v(1,0,32'h0,0,0,32'h0,   0,0,0,32'h0,    1,32'h3, 0,32'h40));
    // starvation: four MEM wins, then forced IF, then MEM resumes
    vq.push_back(v(1,1,32'h30,0,1,32'h200, 0,1,1,32'h200, 0,32'h3, 0,32'h40));
    vq.push_back(v(1,1,32'h30,0,1,32'h200, 0,1,1,32'h200, 0,32'h3, 1,32'h80));
    vq.push_back(v(1,1,32'h30,0,1,32'h200, 0,1,1,32'h200, 0,32'h3, 1,32'h80));
    vq.push_back(v(1,1,32'h30,0,1,32'h200, 0,1,1,32'h200, 0,32'h3, 1,32'h80));
    vq.push_back(v(1,1,32'h30,0,1,32'h200, 1,0,1,32'h30,  0,32'h3, 1,32'h80));
    vq.push_back(v(1,0,32'h0,0,1,32'h200,  0,1,1,32'h200, 1,32'hC, 0,32'h80));
    // flush in grant cycle, then new fetch at 0x20
    vq.push_back(v(1,1,32'h10,1,0,32'h0,  1,0,1,32'h10,   0,32'hC, 1,32'h80));
    vq.push_back(v(1,1,32'h20,0,0,32'h0,  1,0,1,32'h20,   0,32'hC, 0,32'h80));
    vq.push_back(v(1,0,32'h0,0,0,32'h0,   0,0,0,32'h0,    1,32'h8, 0,32'h80));
    // flush in presentation cycle
    vq.push_back(v(1,1,32'h14,0,0,32'h0,  1,0,1,32'h14,   0,32'h8, 0,32'h80));
    vq.push_back(v(1,0,32'h0,1,0,32'h0,   0,0,0,32'h0,    0,32'h8, 0,32'h80));
    vq.push_back(v(1,0,32'h0,0,0,32'h0,   0,0,0,32'h0,    0,32'h8, 0,32'h80));

    s = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    drive(s);
    next_cycle();

    foreach (vq[i]) begin
      drive(vq[i].stim);
      @(negedge clk);
      got = '{if_gnt, mem_gnt, rom_bus.ce, rom_bus.addr, if_rvalid, if_rdata, mem_rvalid, mem_rdata};
      total++;
      if (got === vq[i].exp) passed++;
      else $display("FAIL row%0d: got ig=%b mg=%b ce=%b ra=%h irv=%b ird=%h mrv=%b mrd=%h expected ig=%b mg=%b ce=%b ra=%h irv=%b ird=%h mrv=%b mrd=%h",
                    i, got.if_gnt, got.mem_gnt, got.ce, got.rom_addr, got.if_rvalid, got.if_rdata,
                    got.mem_rvalid, got.mem_rdata, vq[i].exp.if_gnt, vq[i].exp.mem_gnt, vq[i].exp.ce,
                    vq[i].exp.rom_addr, vq[i].exp.if_rvalid, vq[i].exp.if_rdata, vq[i].exp.mem_rvalid,
                    vq[i].exp.mem_rdata);
      next_cycle();
    end

    // reset dropped while MEM would be granted again: in-flight state discarded
    s = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h104};
    drive(s);
    @(negedge clk);
    chk("seq6_mem_gnt", {31'd0, mem_gnt}, 32'd1);
    next_cycle();
    s.rst_n = 1'b0;
    drive(s);
    @(negedge clk);
    chk("seq6_cnt_before", {28'd0, dut.u_starve.cnt}, 32'd1);
    chk("seq6_gnt_in_reset", {30'd0, if_gnt, mem_gnt}, 32'd0);
    next_cycle();
    s = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    drive(s);
    @(negedge clk);
    chk("seq6_rvalid_after", {30'd0, if_rvalid, mem_rvalid}, 32'd0);
    chk("seq6_state", {30'd0, dut.state}, {30'd0, ARB_IDLE});
    chk("seq6_cnt_after", {28'd0, dut.u_starve.cnt}, 32'd0);
    chk("seq6_mem_rdata", mem_rdata, 32'd0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
